// File: rtl/tournament_chooser_table_pkg.sv
// Shared types and helpers for the tournament chooser: counter constants,
// checkpoint layout, chooser state encoding and the saturating counter step.
package tournament_pkg;

    localparam int CK_INDEX_W = 16;
    localparam int CK_PRED_W  = 8;

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } chooser_state_t;

    // Sized for the largest supported table and component count; users take the low bits.
    typedef struct packed {
        logic [CK_INDEX_W-1:0] index;
        logic [CK_PRED_W-1:0]  comp_pred;
    } checkpoint_t;

    function automatic int ctr_mid(input int w);
        return 1 << (w - 1);
    endfunction

    function automatic int ctr_max(input int w);
        return (1 << w) - 1;
    endfunction

    function automatic int sat_step(input int ctr, input logic up, input int max);
        if (up) return (ctr >= max) ? max : ctr + 1;
        return (ctr <= 0) ? 0 : ctr - 1;
    endfunction

endpackage

// File: rtl/tournament_chooser_table_if.sv
// Fetch-side bundle of the tournament chooser: lookup, prediction, resolve and status.
interface tournament_chooser_table_if
    import tournament_pkg::*;
#(
    parameter int N_PRED   = 3,
    parameter int PC_WIDTH = 32
);
    localparam int SEL_W = (N_PRED > 1) ? $clog2(N_PRED) : 1;

    // A lookup transfers on a rising edge where lookup_valid && lookup_ready; fetch may
    // hold lookup_valid while ready is low, and the result is a one-cycle pred_valid pulse
    // on the following cycle. resolve_valid and flush are single-cycle strobes, never stalled.
    logic                lookup_valid;
    logic                lookup_ready;
    logic [PC_WIDTH-1:0] lookup_pc;
    logic [N_PRED-1:0]   comp_pred;
    logic                pred_valid;
    logic                pred_out;
    logic [SEL_W-1:0]    pred_sel;
    logic                resolve_valid;
    logic                outcome;
    logic                flush;
    logic                fifo_full;
    logic                underflow_err;
    chooser_state_t      dbg_state;

    modport master (
        output lookup_valid, lookup_pc, comp_pred, resolve_valid, outcome, flush,
        input  lookup_ready, pred_valid, pred_out, pred_sel, fifo_full, underflow_err,
               dbg_state
    );

    modport slave (
        input  lookup_valid, lookup_pc, comp_pred, resolve_valid, outcome, flush,
        output lookup_ready, pred_valid, pred_out, pred_sel, fifo_full, underflow_err,
               dbg_state
    );

endinterface

// File: rtl/tournament_chooser_table_fifo.sv
// In-order checkpoint FIFO for branch predictors: push/pop/flush with registered full flag.
module pred_checkpoint_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic [CW-1:0]    count_o,
    output logic             empty_o,
    output logic             full_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q;
    logic             push_ok, pop_ok;

    // A full FIFO refuses a push even when a pop lands in the same cycle.
    assign push_ok = push_i && !full_q;
    assign pop_ok  = pop_i && (count_q != '0);

    always_comb begin
        count_d = count_q;
        if (flush_i) begin
            count_d = '0;
        end else if (push_ok && !pop_ok) begin
            count_d = count_q + CW'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            full_q  <= (count_d == CW'(DEPTH));
            if (flush_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
                if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush_i) mem_q[wr_ptr_q] <= din_i;
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);
    assign full_o  = full_q;

endmodule

// File: rtl/tournament_chooser_table.sv
// Tournament chooser: PC-indexed rank counters pick the best component prediction,
// and in-order checkpoints train each row against what the components said at lookup.
module tournament_chooser_table
    import tournament_pkg::*;
#(
    parameter int N_PRED     = 3,
    parameter int CTR_WIDTH  = 2,
    parameter int INDEX_BITS = 6,
    parameter int PC_WIDTH   = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    tournament_chooser_table_if.slave  bus
);
    localparam int SEL_W     = (N_PRED > 1) ? $clog2(N_PRED) : 1;
    localparam int ROWS      = 1 << INDEX_BITS;
    localparam int CTR_MAX_V = ctr_max(CTR_WIDTH);
    localparam logic [CTR_WIDTH-1:0] CTR_MID_V = CTR_WIDTH'(ctr_mid(CTR_WIDTH));
    localparam int CW        = ((FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1) + 1;

    chooser_state_t          state_q;
    logic [INDEX_BITS-1:0]   init_ptr_q;
    logic                    pred_valid_q, pred_out_q, underflow_q;
    logic [SEL_W-1:0]        pred_sel_q;
    logic [CTR_WIDTH-1:0]    table_q [ROWS][N_PRED];
    logic [CTR_WIDTH-1:0]    upd_row [N_PRED];

    logic [PC_WIDTH-1:0]     pc;
    logic [INDEX_BITS-1:0]   lk_index, head_idx;
    logic [N_PRED-1:0]       head_pred;
    logic [SEL_W-1:0]        best_sel;
    logic [CTR_WIDTH-1:0]    best_val;
    logic                    in_ready, lookup_ready, lookup_fire;
    logic                    do_resolve, do_flush, pop, push;
    checkpoint_t             ck_push, head;
    logic [$bits(checkpoint_t)-1:0] fifo_dout;
    logic [CW-1:0]           fifo_count;
    logic                    fifo_empty, fifo_full;
    logic                    unused_bits;

    assign pc           = bus.lookup_pc;
    assign lk_index     = pc[INDEX_BITS+1:2];
    assign in_ready     = (state_q == ST_READY);
    assign lookup_ready = in_ready && !fifo_full;
    assign lookup_fire  = bus.lookup_valid && lookup_ready;
    assign do_resolve   = in_ready && bus.resolve_valid;
    assign do_flush     = in_ready && bus.flush;
    assign pop          = do_resolve && !fifo_empty;
    assign push         = lookup_fire && !do_flush;

    assign ck_push.index     = CK_INDEX_W'(lk_index);
    assign ck_push.comp_pred = CK_PRED_W'(bus.comp_pred);
    assign head              = checkpoint_t'(fifo_dout);
    assign head_idx          = head.index[INDEX_BITS-1:0];
    assign head_pred         = head.comp_pred[N_PRED-1:0];
    assign unused_bits       = ^{head, pc, fifo_count};

    pred_checkpoint_fifo #(
        .WIDTH ($bits(checkpoint_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (do_flush),
        .din_i   (ck_push),
        .dout_o  (fifo_dout),
        .count_o (fifo_count),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    // Strict greater-than keeps ties on the lowest-numbered component.
    always_comb begin
        best_sel = '0;
        best_val = table_q[lk_index][0];
        for (int i = 1; i < N_PRED; i++) begin
            if (table_q[lk_index][i] > best_val) begin
                best_val = table_q[lk_index][i];
                best_sel = SEL_W'(i);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N_PRED; i++) begin
            upd_row[i] = CTR_WIDTH'(sat_step(int'(table_q[head_idx][i]),
                                             head_pred[i] == bus.outcome, CTR_MAX_V));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_INIT;
            init_ptr_q   <= '0;
            pred_valid_q <= 1'b0;
            pred_out_q   <= 1'b0;
            pred_sel_q   <= '0;
            underflow_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    pred_valid_q <= 1'b0;
                    init_ptr_q   <= init_ptr_q + INDEX_BITS'(1);
                    if (init_ptr_q == '1) state_q <= ST_READY;
                end
                ST_READY: begin
                    pred_valid_q <= lookup_fire;
                    if (lookup_fire) begin
                        pred_out_q <= bus.comp_pred[best_sel];
                        pred_sel_q <= best_sel;
                    end
                    if (do_resolve && fifo_empty) underflow_q <= 1'b1;
                end
                default: state_q <= ST_INIT;
            endcase
        end
    end

    // Table is a plain memory: INIT rewrites every row, so it needs no reset of its own.
    always_ff @(posedge clk) begin
        if (state_q == ST_INIT) begin
            for (int i = 0; i < N_PRED; i++) table_q[init_ptr_q][i] <= CTR_MID_V;
        end else if (pop) begin
            for (int i = 0; i < N_PRED; i++) table_q[head_idx][i] <= upd_row[i];
        end
    end

    assign bus.lookup_ready  = lookup_ready;
    assign bus.pred_valid    = pred_valid_q;
    assign bus.pred_out      = pred_out_q;
    assign bus.pred_sel      = pred_sel_q;
    assign bus.fifo_full     = fifo_full;
    assign bus.underflow_err = underflow_q;
    assign bus.dbg_state     = state_q;

endmodule

// File: doc/tournament_chooser_table.md
Name: tournament_chooser_table

Overview:
- Parametrised N-way chooser for the tournament branch predictor.
- Holds a PC-indexed table of per-component saturating rank counters and selects the best-ranked component prediction per lookup.
- Keeps in-order checkpoints of in-flight predictions, so resolution trains the counters against what each component predicted at lookup time.
- Sits between the component predictors (gshare/bimodal/local, or more) and fetch.

Parameters:
- N_PRED, 3, number of component predictors (2..8).
- CTR_WIDTH, 2, rank counter width in bits (2..4).
- INDEX_BITS, 6, log2 of table depth; index = lookup_pc[INDEX_BITS+1:2].
- PC_WIDTH, 32, program counter width.
- FIFO_DEPTH, 4, in-flight checkpoint capacity (power of 2, >=2).
- Derived localparam SEL_W = max(1, clog2(N_PRED)).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- lookup_valid  in  1  fetch requests a prediction.
- lookup_ready  out  1  chooser can accept a lookup.
- lookup_pc  in  PC_WIDTH  branch PC.
- comp_pred  in  N_PRED  component predictions for lookup_pc, bit i = predictor i.
- pred_valid  out  1  prediction output valid.
- pred_out  out  1  chosen taken/not-taken.
- pred_sel  out  SEL_W  index of the chosen component.
- resolve_valid  in  1  oldest in-flight branch resolved.
- outcome  in  1  actual direction of the resolved branch.
- flush  in  1  squash all in-flight checkpoints.
- fifo_full  out  1  checkpoint FIFO full.
- underflow_err  out  1  sticky: resolve_valid seen with FIFO empty.

Behaviour:
- Reset (reset=0, asynchronous): state=INIT, init pointer=0, FIFO empty. Outputs: lookup_ready=0, pred_valid=0, pred_out=0, pred_sel=0, fifo_full=0, underflow_err=0.
- INIT state: writes one table row per cycle, every counter set to midpoint 2^(CTR_WIDTH-1). Takes exactly 2^INDEX_BITS cycles, then moves to READY. lookup_ready=0 throughout INIT. resolve_valid and flush are ignored in INIT.
- READY state: lookup_ready = !fifo_full. Reset asserted mid-operation returns the block to INIT and discards all checkpoints.
- Lookup handshake: lookup_valid && lookup_ready.
  - Read row[index] and choose the component with the highest counter value; ties go to the lowest index.
  - Next cycle: pred_valid=1, pred_out=comp_pred[sel], pred_sel=sel (1-cycle latency).
  - pred_valid is a single-cycle pulse per handshake. Back-to-back lookups give back-to-back outputs.
  - The handshake pushes checkpoint {index, comp_pred} into the FIFO.
- Resolve (resolve_valid, FIFO non-empty): pop the head checkpoint and update row[head.index]. For each component i:
  - counter +1, saturating at 2^CTR_WIDTH-1, if comp_pred[i]==outcome;
  - otherwise counter -1, saturating at 0.
  - All N_PRED counters of the row update in the same cycle. No unsigned wrap-around under any condition.
- Resolve with FIFO empty: no table change; underflow_err set to 1 and held until reset.
- Simultaneous lookup and resolve:
  - push and pop happen in the same cycle, so occupancy is unchanged;
  - if the indices match, the lookup sees the pre-update counters (read-before-write).
- Full FIFO: lookup_ready=0 even if a resolve is present in the same cycle (no bypass).
- Flush: empties the FIFO next cycle.
  - A resolve in the same cycle is applied first (head trains the table), then the remaining checkpoints are discarded.
  - A lookup in the same cycle is discarded too: no checkpoint is kept, but the output pulse still occurs.
- Flush never touches the table.
- fifo_full = (count == FIFO_DEPTH), registered and consistent with count.

Decomposition:
- Package tournament_pkg holds:
  - CTR_MID and CTR_MAX constant functions of CTR_WIDTH;
  - the checkpoint struct typedef {index, comp_pred};
  - the chooser state enum {INIT, READY};
  - a saturating-update function sat_step(ctr, up).
- One sub-module: pred_checkpoint_fifo (synchronous FIFO with push/pop/flush/count). It is reusable by other predictors.

Test Plan:
- Reset with defaults, hold READY: lookup_ready rises exactly 64 cycles after reset deassert. A lookup with comp_pred=3'b010 then returns pred_sel=0, pred_out=0 (all counters 2, tie goes to index 0).
- Train index 5: four lookups with comp_pred=3'b100, each resolved with outcome=1 → row5={0,0,3}. Next lookup at index 5 with comp_pred=3'b100 → pred_sel=2, pred_out=1.
- Saturation: ten resolves with component 0 always correct → counter 0 stays 3 and never wraps to 0. Components 1 and 2 always wrong → stay at 0.
- FIFO full: four lookups with no resolve → fifo_full=1, lookup_ready=0. One resolve drops fifo_full and lookup_ready returns 1 the next cycle.
- Flush with resolve together, three in flight: head row updated, count=0 next cycle. A further resolve sets underflow_err=1, which holds until reset.
- Async reset asserted mid-train: outputs go to 0 immediately, INIT re-runs, and all counters read back as 2.
